// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome tempo path.
package metronome_pkg;

  localparam int BCD_DIGITS = 3;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  // Double-dabble correction applied to each nibble before a shift
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bpm_adjuster_bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter.
// A start in any state restarts from LOAD, so only the latest value is ever published.
module bin_to_bcd_seq
  import metronome_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_bin,
  output bcd_digit_t       o_digit_100,
  output bcd_digit_t       o_digit_10,
  output bcd_digit_t       o_digit_1,
  output logic             o_done
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(WIDTH - 1);

  conv_state_t             r_state;
  conv_state_t             w_state_next;
  logic [WIDTH-1:0]        r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [BCD_W-1:0]        r_digits;
  logic [CNT_W-1:0]        r_cnt;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W+WIDTH-1:0]  w_shifted;
  logic                    w_last;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = add3(r_bcd[4*gi +: 4]);
    end
  endgenerate

  assign w_shifted = {w_bcd_adj, r_bin} << 1;
  assign w_last    = (r_state == SHIFT) && (r_cnt == L_LAST);
  // o_done marks the edge on which the digits take their new value
  assign o_done    = w_last && !i_start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_start) w_state_next = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == LOAD) begin
        r_bin <= i_bin;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        {r_bcd, r_bin} <= w_shifted;
        r_cnt          <= r_cnt + CNT_W'(1);
      end
      if (o_done) r_digits <= w_shifted[BCD_W+WIDTH-1 -: BCD_W];
    end
  end

  assign o_digit_100 = r_digits[8 +: 4];
  assign o_digit_10  = r_digits[4 +: 4];
  assign o_digit_1   = r_digits[0 +: 4];

endmodule

// File: rtl/bpm_adjuster.sv
// Button-driven saturating tempo setter with BCD readout.
// Optional hold-to-repeat stepping is enabled by defining AUTO_REPEAT_EN.
module bpm_adjuster
  import metronome_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_BPM      = 40,
  parameter int MAX_BPM      = 240,
  parameter int RESET_BPM    = 120,
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic             dir,
  output logic [WIDTH-1:0] bpm,
  output logic             bpm_changed,
  output bcd_digit_t       digit_100,
  output bcd_digit_t       digit_10,
  output bcd_digit_t       digit_1,
  output logic             bcd_valid
);

  localparam logic [WIDTH:0]   L_MAX      = (WIDTH+1)'(MAX_BPM);
  localparam logic [WIDTH:0]   L_MIN_STEP = (WIDTH+1)'(MIN_BPM + STEP);
  localparam logic [WIDTH:0]   L_STEP     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] L_MAX_W    = WIDTH'(MAX_BPM);
  localparam logic [WIDTH-1:0] L_MIN_W    = WIDTH'(MIN_BPM);
  localparam logic [WIDTH-1:0] L_STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] L_RESET_W  = WIDTH'(RESET_BPM);

  logic             r_btn_s1, r_btn_s2, r_btn_prev;
  logic             r_dir_s1, r_dir_s2;
  logic [WIDTH-1:0] r_bpm;
  logic             r_bpm_changed;
  logic             r_bcd_valid;
  logic             r_init;
  logic             w_press, w_step, w_changed, w_conv_done;
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH-1:0] w_bpm_up, w_bpm_dn, w_bpm_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1   <= 1'b1;
      r_btn_s2   <= 1'b1;
      r_btn_prev <= 1'b1;
      r_dir_s1   <= 1'b0;
      r_dir_s2   <= 1'b0;
    end else begin
      r_btn_s1   <= btn_n;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
      r_dir_s1   <= dir;
      r_dir_s2   <= r_dir_s1;
    end
  end

  assign w_press = r_btn_prev & ~r_btn_s2;

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] L_DELAY  = 32'(REPEAT_DELAY);
  localparam logic [31:0] L_RELOAD = 32'(REPEAT_DELAY - REPEAT_RATE);
  logic [31:0] r_hold_cnt;
  logic        w_repeat;

  // Reloading to DELAY-RATE makes later repeats land every REPEAT_RATE cycles
  assign w_repeat = ~r_btn_s2 & (r_hold_cnt == L_DELAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_hold_cnt <= '0;
    else if (r_btn_s2)   r_hold_cnt <= '0;
    else if (w_repeat)   r_hold_cnt <= L_RELOAD;
    else                 r_hold_cnt <= r_hold_cnt + 32'd1;
  end

  assign w_step = w_press | w_repeat;
`else
  logic [31:0] w_unused_repeat;
  assign w_unused_repeat = 32'(REPEAT_DELAY) ^ 32'(REPEAT_RATE);
  assign w_step = w_press;
`endif

  assign w_up_sum   = {1'b0, r_bpm} + L_STEP;
  assign w_bpm_up   = (w_up_sum > L_MAX) ? L_MAX_W : w_up_sum[WIDTH-1:0];
  assign w_bpm_dn   = ({1'b0, r_bpm} < L_MIN_STEP) ? L_MIN_W : r_bpm - L_STEP_W;
  assign w_bpm_next = w_step ? (r_dir_s2 ? w_bpm_up : w_bpm_dn) : r_bpm;
  assign w_changed  = (w_bpm_next != r_bpm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bpm         <= L_RESET_W;
      r_bpm_changed <= 1'b0;
      r_bcd_valid   <= 1'b0;
      r_init        <= 1'b1;
    end else begin
      r_bpm         <= w_bpm_next;
      r_bpm_changed <= w_changed;
      r_init        <= 1'b0;
      if (w_changed)        r_bcd_valid <= 1'b0;
      else if (w_conv_done) r_bcd_valid <= 1'b1;
    end
  end

  // r_init kicks off the conversion of the reset value on the first edge
  bin_to_bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (r_bpm_changed | r_init),
    .i_bin       (r_bpm),
    .o_digit_100 (digit_100),
    .o_digit_10  (digit_10),
    .o_digit_1   (digit_1),
    .o_done      (w_conv_done)
  );

  assign bpm         = r_bpm;
  assign bpm_changed = r_bpm_changed;
  assign bcd_valid   = r_bcd_valid;

endmodule

// File: tb/tb_bpm_adjuster.sv
// Directed bench for bpm_adjuster; expected repeat count follows AUTO_REPEAT_EN.
module tb_bpm_adjuster;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       dir = 1'b1;
  logic [7:0] bpm;
  logic       bpm_changed;
  logic [3:0] digit_100, digit_10, digit_1;
  logic       bcd_valid;

  int n_total = 0;
  int n_fail  = 0;
  int tot_changed = 0;
  int tot_rise = 0;
  int tot_041 = 0;
  logic prev_valid = 1'b0;
  int c0, r0, a0;

  always #5 clk = ~clk;

  bpm_adjuster #(
    .WIDTH(8), .MIN_BPM(40), .MAX_BPM(240), .RESET_BPM(120), .STEP(1),
    .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .dir(dir),
    .bpm(bpm), .bpm_changed(bpm_changed),
    .digit_100(digit_100), .digit_10(digit_10), .digit_1(digit_1),
    .bcd_valid(bcd_valid)
  );

  always @(negedge clk) begin
    if (bpm_changed) tot_changed <= tot_changed + 1;
    if (bcd_valid && !prev_valid) tot_rise <= tot_rise + 1;
    prev_valid <= bcd_valid;
    if ({digit_100, digit_10, digit_1} == 12'h041) tot_041 <= tot_041 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic press();
    btn_n = 1'b0;
    tick(4);
    btn_n = 1'b1;
    tick(4);
  endtask

  function automatic int digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    return int'({h, t, o});
  endfunction

  initial begin
    int exp_up[4];
    int exp_dn[4];
    exp_up = '{239, 240, 240, 240};
    exp_dn = '{41, 40, 40, 40};

    // Reset and first conversion
    tick(3);
    chk("rst_bpm", int'(bpm), 120);
    chk("rst_changed", int'(bpm_changed), 0);
    chk("rst_valid", int'(bcd_valid), 0);
    chk("rst_digits", digits(digit_100, digit_10, digit_1), 'h000);
    rst_n = 1'b1;
    tick(9);
    chk("init_valid_early", int'(bcd_valid), 0);
    chk("init_digits_early", digits(digit_100, digit_10, digit_1), 'h000);
    tick(1);
    chk("init_valid", int'(bcd_valid), 1);
    chk("init_digits", digits(digit_100, digit_10, digit_1), 'h120);

    // Five up presses
    dir = 1'b1;
    c0 = tot_changed;
    for (int i = 1; i <= 5; i++) begin
      press();
      chk("up_bpm", int'(bpm), 120 + i);
    end
    tick(12);
    chk("up_pulses", tot_changed - c0, 5);
    chk("up_digits", digits(digit_100, digit_10, digit_1), 'h125);
    chk("up_valid", int'(bcd_valid), 1);

    // Upper saturation
    repeat (113) press();
    chk("pre_max_bpm", int'(bpm), 238);
    c0 = tot_changed;
    for (int i = 0; i < 4; i++) begin
      press();
      chk("sat_up_bpm", int'(bpm), exp_up[i]);
    end
    tick(12);
    chk("sat_up_pulses", tot_changed - c0, 2);
    chk("sat_up_digits", digits(digit_100, digit_10, digit_1), 'h240);
    chk("sat_up_valid", int'(bcd_valid), 1);

    // Lower saturation
    dir = 1'b0;
    repeat (198) press();
    chk("pre_min_bpm", int'(bpm), 42);
    c0 = tot_changed;
    for (int i = 0; i < 4; i++) begin
      press();
      chk("sat_dn_bpm", int'(bpm), exp_dn[i]);
    end
    tick(12);
    chk("sat_dn_pulses", tot_changed - c0, 2);
    chk("sat_dn_digits", digits(digit_100, digit_10, digit_1), 'h040);

    // Two presses inside one conversion window
    dir = 1'b1;
    r0 = tot_rise;
    a0 = tot_041;
    btn_n = 1'b0; tick(2);
    btn_n = 1'b1; tick(2);
    btn_n = 1'b0; tick(2);
    btn_n = 1'b1; tick(20);
    chk("rs_bpm", int'(bpm), 42);
    chk("rs_valid_rises", tot_rise - r0, 1);
    chk("rs_no_interim", tot_041 - a0, 0);
    chk("rs_digits", digits(digit_100, digit_10, digit_1), 'h042);
    chk("rs_valid", int'(bcd_valid), 1);

    // Asynchronous reset in the middle of a conversion
    btn_n = 1'b0;
    tick(7);
    chk("pre_arst_bpm", int'(bpm), 43);
    chk("pre_arst_valid", int'(bcd_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bpm", int'(bpm), 120);
    chk("arst_changed", int'(bpm_changed), 0);
    chk("arst_valid", int'(bcd_valid), 0);
    chk("arst_digits", digits(digit_100, digit_10, digit_1), 'h000);
    btn_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("arst_rel_valid", int'(bcd_valid), 1);
    chk("arst_rel_digits", digits(digit_100, digit_10, digit_1), 'h120);

    // Long hold
    dir = 1'b1;
    c0 = tot_changed;
    btn_n = 1'b0;
    tick(43);
    btn_n = 1'b1;
    tick(6);
`ifdef AUTO_REPEAT_EN
    chk("hold_bpm", int'(bpm), 126);
    chk("hold_pulses", tot_changed - c0, 6);
`else
    chk("hold_bpm", int'(bpm), 121);
    chk("hold_pulses", tot_changed - c0, 1);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
